// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// {pc, opcode} buffer to the decoder, redirect squash and WFI sleep/wake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        sleep_req,
  input  logic        wake,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_opcode,
  output logic [31:0] inst_pc,
  output logic        sleeping
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {RUN, SLEEP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, rsp_pc_reg;
  logic [CW-1:0] outstanding_reg, drop_cnt_reg, count_reg;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [31:0]   op_arr [DEPTH];
  logic [31:0]   tag_arr [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;
  logic          req_fire, push, pop;

  assign credit_used      = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign push             = imem_rsp_valid & (drop_cnt_reg == '0) & ~redirect_valid;
  assign pop              = inst_valid & inst_ready & ~redirect_valid;

  assign imem_req_addr = pc_reg;
  assign inst_valid    = (count_reg != '0);
  assign inst_opcode   = op_arr[rd_ptr_reg];
  assign inst_pc       = tag_arr[rd_ptr_reg];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (sleep_req && !wake) state_next = SLEEP;
      SLEEP:   if (wake)               state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    imem_req_valid = rst_n & (state_reg == RUN) & ~redirect_valid & (credit_used < DEPTH_W);
    sleeping       = (state_reg == SLEEP);
  end

  // A redirect squashes the buffer and marks every word still in flight for dropping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc_reg       <= redirect_aligned;
        rsp_pc_reg   <= redirect_aligned;
        drop_cnt_reg <= outstanding_reg - CW'(imem_rsp_valid);
        count_reg    <= '0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
      end else begin
        if (req_fire) pc_reg <= pc_reg + 32'd4;
        if (imem_rsp_valid) begin
          if (drop_cnt_reg != '0) drop_cnt_reg <= drop_cnt_reg - 1'b1;
          else                    rsp_pc_reg   <= rsp_pc_reg + 32'd4;
        end
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] op_reg, tag_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          op_reg  <= '0;
          tag_reg <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          op_reg  <= imem_rsp_data;
          tag_reg <= rsp_pc_reg;
        end
      end
      assign op_arr[gi]  = op_reg;
      assign tag_arr[gi] = tag_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) assert (credit_used <= DEPTH_W);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        sleep_req;
  logic        wake;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_opcode;
  logic [31:0] inst_pc;
  logic        sleeping;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int mem_lat = 1;
  int req_count = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .sleep_req(sleep_req), .wake(wake),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_pc(inst_pc), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Inputs settle by the falling edge, so the handshake seen here is the one the next edge takes.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] == edge_cnt + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = q_addr[0] + 32'h13;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(edge_cnt + 1 + mem_lat);
        req_count++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && inst_valid && inst_ready)
      $display("deliver pc=%h opcode=%h", inst_pc, inst_opcode);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    req_count = 0;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    sleep_req = 1'b0;
    wake = 1'b0;
    inst_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;

    // reset state
    tick();
    tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_opcode", inst_opcode, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_sleeping", sleeping, 0);

    // streaming, latency 1
    mem_lat = 1;
    rst_n = 1'b1;
    #1;
    chk("s_c0_valid", imem_req_valid, 1);
    chk("s_c0_addr", imem_req_addr, 32'h0);
    tick();
    chk("s_c1_addr", imem_req_addr, 32'h4);
    chk("s_c1_inst_valid", inst_valid, 0);
    tick();
    chk("s_c2_inst_valid", inst_valid, 1);
    chk("s_c2_inst_pc", inst_pc, 32'h0);
    chk("s_c2_opcode", inst_opcode, 32'h13);
    chk("s_c2_req_credit", imem_req_valid, 0);
    tick();
    chk("s_c3_inst_pc", inst_pc, 32'h4);
    chk("s_c3_opcode", inst_opcode, 32'h17);
    chk("s_c3_addr", imem_req_addr, 32'h8);
    tick();
    tick();
    chk("s_c5_inst_pc", inst_pc, 32'h8);
    chk("s_c5_opcode", inst_opcode, 32'h1b);

    // decoder stall fills the credit window
    inst_ready = 1'b0;
    do_reset();
    repeat (9) tick();
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_req_count", req_count, 2);
    chk("stall_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    chk("release_head_pc", inst_pc, 32'h4);
    chk("release_addr", imem_req_addr, 32'h8);
    chk("release_req_valid", imem_req_valid, 1);

    // redirect with two words in flight, latency 3
    mem_lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("redir_req_blocked", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_addr", imem_req_addr, 32'h100);
    tick();
    chk("redir_c4_valid", imem_req_valid, 1);
    chk("redir_c4_inst_valid", inst_valid, 0);
    tick();
    chk("redir_c5_inst_valid", inst_valid, 0);
    tick();
    tick();
    chk("redir_c7_inst_valid", inst_valid, 0);
    tick();
    chk("redir_c8_inst_pc", inst_pc, 32'h100);
    chk("redir_c8_opcode", inst_opcode, 32'h113);

    // misaligned redirect target
    mem_lat = 1;
    inst_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_addr", imem_req_addr, 32'h200);
    tick();
    tick();
    chk("mis_inst_pc", inst_pc, 32'h200);
    chk("mis_opcode", inst_opcode, 32'h213);

    // sleep / wake
    do_reset();
    tick();
    tick();
    tick();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    chk("slp_sleeping", sleeping, 1);
    chk("slp_req_valid", imem_req_valid, 0);
    inst_ready = 1'b1;
    tick();
    chk("slp_drain_pc", inst_pc, 32'h4);
    chk("slp_drain_req", imem_req_valid, 0);
    tick();
    chk("slp_empty", inst_valid, 0);
    tick();
    tick();
    wake = 1'b1;
    tick();
    wake = 1'b0;
    chk("wake_sleeping", sleeping, 0);
    chk("wake_req_valid", imem_req_valid, 1);
    chk("wake_addr", imem_req_addr, 32'h8);
    sleep_req = 1'b1;
    wake = 1'b1;
    tick();
    sleep_req = 1'b0;
    wake = 1'b0;
    chk("slp_wake_same", sleeping, 0);

    // PC wrap then reset with a full buffer
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_zero", imem_req_addr, 32'h0);
    tick();
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_opcode", inst_opcode, 32'h0000_000F);
    inst_ready = 1'b0;
    tick();
    chk("full_inst_valid", inst_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_req_valid", imem_req_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_addr", imem_req_addr, 32'h0);
    chk("midrst_req_after", imem_req_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
